// File: rtl/predict_sequencer.sv
// Argmax sequencer: collects NUM_CLASSES signed scores in class order and reports
// the index and value of the highest one (ties go to the lowest index).
// Latency: predict/predict_score update one edge after the last accepted score;
// predict_ok pulses in the following cycle.
// Backpressure: score_ready is high only in COLLECT. Gaps in score_valid stall
// collection indefinitely, and scores offered outside COLLECT are dropped.
//
// Ports:
//   clk, rst           - clock; asynchronous active-high reset
//   start, abort       - begin an inference from IDLE / cancel in COLLECT or RESOLVE
//   score_valid/ready  - valid-ready handshake for score_data
//   score_data         - two's-complement score, class 0 first
//   busy               - high in every state except IDLE
//   predict            - winning class index of the last completed inference
//   predict_score      - winning score of the last completed inference
//   predict_ok         - one-cycle pulse after predict/predict_score update
module predict_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  score_valid,
  input  logic [DATA_WIDTH-1:0] score_data,
  output logic                  score_ready,
  output logic                  busy,
  output logic [IDX_WIDTH-1:0]  predict,
  output logic [DATA_WIDTH-1:0] predict_score,
  output logic                  predict_ok
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

  state_t                        state_q, state_d;
  logic [IDX_WIDTH-1:0]          cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]          best_idx_q, best_idx_d;
  logic signed [DATA_WIDTH-1:0]  best_score_q, best_score_d;
  logic [IDX_WIDTH-1:0]          predict_q, predict_d;
  logic [DATA_WIDTH-1:0]         predict_score_q, predict_score_d;

  logic                          score_gt;

  // Strictly greater keeps the earlier (lower-index) winner on a tie.
  assign score_gt = $signed(score_data) > best_score_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    best_idx_d      = best_idx_q;
    best_score_d    = best_score_q;
    predict_d       = predict_q;
    predict_score_d = predict_score_q;

    case (state_q)
      IDLE: begin
        // abort has no meaning here; start alone decides.
        if (start) begin
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end

      COLLECT: begin
        // abort wins over a transfer offered in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else if (score_valid) begin
          // The first score of an inference seeds the working best
          // unconditionally, so stale values from earlier runs never leak in.
          if ((cnt_q == '0) || score_gt) begin
            best_idx_d   = cnt_q;
            best_score_d = score_data;
          end
          // The counter equals the class index of the score being accepted.
          // It holds at the last index instead of wrapping.
          if (cnt_q == LAST_IDX) begin
            state_d = RESOLVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      RESOLVE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          predict_d       = best_idx_q;
          predict_score_d = best_score_q;
          state_d         = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      best_idx_q      <= '0;
      best_score_q    <= '0;
      predict_q       <= '0;
      predict_score_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      best_idx_q      <= best_idx_d;
      best_score_q    <= best_score_d;
      predict_q       <= predict_d;
      predict_score_q <= predict_score_d;
    end
  end

  // Outputs are decoded from registered state only. Reset therefore clears
  // them combinationally, without waiting for a clock edge.
  assign score_ready   = (state_q == COLLECT);
  assign busy          = (state_q != IDLE);
  assign predict_ok    = (state_q == DONE);
  assign predict       = predict_q;
  assign predict_score = predict_score_q;

endmodule

// File: tb/tb_predict_sequencer.sv
module tb_predict_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       score_valid = 1'b0;
  logic [7:0] score_data = '0;
  logic       score_ready;
  logic       busy;
  logic [3:0] predict;
  logic [7:0] predict_score;
  logic       predict_ok;

  predict_sequencer #(
    .DATA_WIDTH(8),
    .NUM_CLASSES(10),
    .IDX_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .score_valid(score_valid),
    .score_data(score_data),
    .score_ready(score_ready),
    .busy(busy),
    .predict(predict),
    .predict_score(predict_score),
    .predict_ok(predict_ok)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] sc;
  } exp_t;

  exp_t               sb_q[$];
  logic signed [7:0]  scores[10];
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  int                 last_xfer = 0;
  logic               prev_ok = 1'b0;
  logic [3:0]         last_idx = '0;
  logic [7:0]         last_sc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference argmax: strictly-greater update keeps the lowest index on ties.
  function automatic exp_t model();
    exp_t e;
    e.idx = 4'd0;
    e.sc  = scores[0];
    for (int i = 1; i < 10; i++) begin
      if (scores[i] > $signed(e.sc)) begin
        e.idx = 4'(i);
        e.sc  = scores[i];
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: timestamps transfers and scores each predict_ok pulse.
  always @(negedge clk) begin
    if (score_valid && score_ready && !abort && !rst) last_xfer = cyc + 1;
    if (prev_ok) chk("ok_width", {31'b0, predict_ok}, 32'd0);
    if (predict_ok) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("predict", {28'b0, predict}, {28'b0, e.idx});
        chk("predict_score", {24'b0, predict_score}, {24'b0, e.sc});
        chk("latency", cyc - last_xfer, 32'd1);
      end
    end
    prev_ok = predict_ok;
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic send_scores(input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      chk("ready_collect", {31'b0, score_ready}, 32'd1);
      score_valid = 1'b1;
      score_data  = scores[i];
      @(posedge clk); #1;
      score_valid = 1'b0;
      if (stall && i != n - 1) begin
        chk("ready_stall", {31'b0, score_ready}, 32'd1);
        @(posedge clk); #1;
      end
    end
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic full_run(input bit stall, input bit start_while_busy);
    exp_t e;
    e = model();
    sb_q.push_back(e);
    do_start();
    if (start_while_busy) start = 1'b1;
    send_scores(10, stall);
    start = 1'b0;
    wait_idle("idle_after_run");
    last_idx = e.idx;
    last_sc  = e.sc;
    chk("hold_predict", {28'b0, predict}, {28'b0, last_idx});
    chk("hold_score", {24'b0, predict_score}, {24'b0, last_sc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, score_ready}, 32'd0);
    chk("rst_ok", {31'b0, predict_ok}, 32'd0);
    chk("rst_predict", {28'b0, predict}, 32'd0);
    chk("rst_score", {24'b0, predict_score}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // A score offered while IDLE is not taken.
    score_valid = 1'b1;
    score_data  = 8'd55;
    chk("idle_ready", {31'b0, score_ready}, 32'd0);
    @(posedge clk); #1;
    score_valid = 1'b0;

    // Basic back-to-back run.
    scores = '{8'sd3, -8'sd5, 8'sd7, 8'sd2, 8'sd7, 8'sd0, -8'sd128, 8'sd1, 8'sd6, 8'sd7};
    full_run(1'b0, 1'b0);

    // All negative with a three-way tie at -3.
    scores = '{-8'sd9, -8'sd3, -8'sd3, -8'sd100, -8'sd4, -8'sd3, -8'sd50, -8'sd8, -8'sd7, -8'sd128};
    full_run(1'b0, 1'b0);

    // Extremes with alternating valid gaps.
    scores = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128,
               -8'sd128, -8'sd128, -8'sd128, -8'sd128, 8'sd127};
    full_run(1'b1, 1'b0);

    // Abort concurrent with the 6th transfer.
    scores = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50, 8'sd100, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    do_start();
    send_scores(5, 1'b0);
    score_valid = 1'b1;
    score_data  = scores[5];
    abort       = 1'b1;
    @(posedge clk); #1;
    abort       = 1'b0;
    score_valid = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_predict", {28'b0, predict}, {28'b0, last_idx});
    chk("abort_score", {24'b0, predict_score}, {24'b0, last_sc});
    repeat (4) @(posedge clk);
    #1;
    scores = '{8'sd5, 8'sd9, -8'sd2, 8'sd9, 8'sd60, 8'sd0, 8'sd59, 8'sd60, 8'sd3, 8'sd4};
    full_run(1'b0, 1'b0);

    // Start and abort together in IDLE: start wins.
    scores = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9, 8'sd11};
    abort = 1'b1;
    begin
      exp_t e;
      e = model();
      sb_q.push_back(e);
      do_start();
      abort = 1'b0;
      send_scores(10, 1'b0);
      wait_idle("idle_start_abort");
      last_idx = e.idx;
      last_sc  = e.sc;
    end

    // Asynchronous reset between edges in the middle of COLLECT.
    do_start();
    send_scores(3, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ready", {31'b0, score_ready}, 32'd0);
    chk("arst_predict", {28'b0, predict}, 32'd0);
    chk("arst_score", {24'b0, predict_score}, 32'd0);
    #1 rst = 1'b0;
    last_idx = '0;
    last_sc  = '0;
    @(posedge clk); #1;

    // Clean run after reset, with start held high throughout COLLECT.
    scores = '{8'sd4, -8'sd1, 8'sd12, 8'sd0, 8'sd33, 8'sd2, 8'sd8, 8'sd50, 8'sd49, 8'sd50};
    full_run(1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
